// File: rtl/nfc_reg_arb_if.sv
// Signal bundle between the two register masters, the arbiter and the nfc register port.
// The slave side is the arbiter; the master side drives requests and the nfc read data.
interface nfc_reg_arb_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic          m0_req;
    logic          m0_wr;
    logic          m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_din;
    logic          m0_ack;
    logic [DW-1:0] m0_dout;

    logic          m1_req;
    logic          m1_wr;
    logic          m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_din;
    logic          m1_ack;
    logic [DW-1:0] m1_dout;

    logic [AW-1:0] arb_nfc_reg_addr;
    logic          arb_nfc_reg_rd;
    logic          arb_nfc_reg_wr;
    logic [DW-1:0] arb_nfc_reg_din;
    logic [DW-1:0] nfc_arb_reg_dout;
    logic          arb_owner;
    logic          arb_lock_to;

    modport slave (
        input  m0_req, m0_wr, m0_lock, m0_addr, m0_din,
        input  m1_req, m1_wr, m1_lock, m1_addr, m1_din,
        input  nfc_arb_reg_dout,
        output m0_ack, m0_dout, m1_ack, m1_dout,
        output arb_nfc_reg_addr, arb_nfc_reg_rd, arb_nfc_reg_wr, arb_nfc_reg_din,
        output arb_owner, arb_lock_to
    );

    modport master (
        output m0_req, m0_wr, m0_lock, m0_addr, m0_din,
        output m1_req, m1_wr, m1_lock, m1_addr, m1_din,
        output nfc_arb_reg_dout,
        input  m0_ack, m0_dout, m1_ack, m1_dout,
        input  arb_nfc_reg_addr, arb_nfc_reg_rd, arb_nfc_reg_wr, arb_nfc_reg_din,
        input  arb_owner, arb_lock_to
    );
endinterface

// File: rtl/nfc_reg_arb.sv
// Two-master arbiter for the nfc register port: fixed 4-cycle access, alternating
// tie-break, and an owner lock with an optional idle timeout.
module nfc_reg_arb #(
    parameter int AW           = 9,
    parameter int DW           = 8,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic          nfc_clk,
    input  logic          rstb_nfc,
    nfc_reg_arb_if.slave  bus
);
    localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;
    state_t state, state_nx;

    logic          owner, last, lock, lock_nx, is_rd;
    logic          e0, e1, sel, grant, own_req, own_lk, lto_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q, dout0, dout1;
    logic          rd_q, wr_q, ack0, ack1, lto_q;

    // While locked only the owner is eligible; a tie goes to whoever was not granted last.
    always_comb begin
        e0      = bus.m0_req && (!lock || !owner);
        e1      = bus.m1_req && (!lock ||  owner);
        sel     = (e0 && e1) ? ~last : e1;
        grant   = e0 | e1;
        own_req = owner ? bus.m1_req  : bus.m0_req;
        own_lk  = owner ? bus.m1_lock : bus.m0_lock;
    end

    always_comb begin
        state_nx = state;
        lock_nx  = lock;
        cnt_nx   = cnt;
        lto_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (lock && !own_lk) begin
                    lock_nx = 1'b0;
                    cnt_nx  = '0;
                end else if (lock && !own_req && LOCK_TIMEOUT != 0) begin
                    if (int'(cnt) + 1 >= LOCK_TIMEOUT) begin
                        lock_nx = 1'b0;
                        cnt_nx  = '0;
                        lto_nx  = 1'b1;
                    end else if (cnt != '1) begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                if (grant) begin
                    state_nx = ISSUE;
                    if (sel == owner) cnt_nx = '0;
                end
            end
            ISSUE:   state_nx = CAPTURE;
            CAPTURE: state_nx = ACK;
            ACK: begin
                state_nx = IDLE;
                lock_nx  = own_lk;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
        if (!rstb_nfc) state <= IDLE;
        else           state <= state_nx;
    end

    // Strobe and bus fields are single-cycle: everything defaults back to 0 each clock.
    always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
        if (!rstb_nfc) begin
            owner  <= 1'b0;
            last   <= 1'b1;
            lock   <= 1'b0;
            cnt    <= '0;
            is_rd  <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            dout0  <= '0;
            dout1  <= '0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            lto_q  <= 1'b0;
        end else begin
            lock   <= lock_nx;
            cnt    <= cnt_nx;
            lto_q  <= lto_nx;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    owner  <= sel;
                    is_rd  <= sel ? !bus.m1_wr : !bus.m0_wr;
                    rd_q   <= sel ? !bus.m1_wr : !bus.m0_wr;
                    wr_q   <= sel ?  bus.m1_wr :  bus.m0_wr;
                    addr_q <= sel ?  bus.m1_addr : bus.m0_addr;
                    din_q  <= sel ?  bus.m1_din  : bus.m0_din;
                end
                CAPTURE: begin
                    if (is_rd &&  owner) dout1 <= bus.nfc_arb_reg_dout;
                    if (is_rd && !owner) dout0 <= bus.nfc_arb_reg_dout;
                    ack1 <=  owner;
                    ack0 <= !owner;
                end
                ACK: last <= owner;
                default: ;
            endcase
        end
    end

    assign bus.arb_nfc_reg_addr = addr_q;
    assign bus.arb_nfc_reg_rd   = rd_q;
    assign bus.arb_nfc_reg_wr   = wr_q;
    assign bus.arb_nfc_reg_din  = din_q;
    assign bus.m0_ack           = ack0;
    assign bus.m1_ack           = ack1;
    assign bus.m0_dout          = dout0;
    assign bus.m1_dout          = dout1;
    assign bus.arb_owner        = owner;
    assign bus.arb_lock_to      = lto_q;
endmodule

// File: tb/tb_nfc_reg_arb.sv
// Bench for nfc_reg_arb: directed scenarios plus two random masters, checked by a
// timestamp-based reference model feeding a scoreboard queue drained by a monitor.
module tb_nfc_reg_arb;
    localparam int LT = 8;

    logic nfc_clk;
    logic rstb_nfc;
    nfc_reg_arb_if #(.AW(9), .DW(8)) bus();

    nfc_reg_arb #(.AW(9), .DW(8), .LOCK_TIMEOUT(LT)) dut (
        .nfc_clk  (nfc_clk),
        .rstb_nfc (rstb_nfc),
        .bus      (bus)
    );

    typedef struct {
        int         scyc;
        bit         m;
        bit         wr;
        logic [8:0] addr;
        logic [7:0] din;
    } item_t;

    item_t      q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         exp_lto = -1;
    bit         dout_rand = 1'b1;
    logic [7:0] hist[16];
    logic [7:0] last_dout[2];

    initial begin
        nfc_clk = 1'b0;
        forever #5 nfc_clk = ~nfc_clk;
    end

    always @(posedge nfc_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: arbitration rules evaluated once per idle cycle; a grant in
    // cycle T predicts a strobe at T+1 and an ack at T+3.
    bit busy, mlock, mlast, mown;
    int gcyc, idle_cnt;
    always @(negedge nfc_clk) begin
        bit o_req, o_lk, e0, e1, sel;
        if (!rstb_nfc) begin
            busy = 0; mlock = 0; mlast = 1; mown = 0; idle_cnt = 0;
            q.delete();
        end else if (busy) begin
            if (cyc == gcyc + 3) begin
                mlast = mown;
                mlock = mown ? bus.m1_lock : bus.m0_lock;
                busy  = 0;
            end
        end else begin
            o_req = mown ? bus.m1_req  : bus.m0_req;
            o_lk  = mown ? bus.m1_lock : bus.m0_lock;
            e0 = bus.m0_req && (!mlock || mown == 0);
            e1 = bus.m1_req && (!mlock || mown == 1);
            sel = (e0 && e1) ? !mlast : e1;
            if (mlock) begin
                if (!o_lk) begin
                    mlock = 0; idle_cnt = 0;
                end else if (!o_req) begin
                    idle_cnt++;
                    if (idle_cnt == LT) begin
                        mlock = 0; idle_cnt = 0; exp_lto = cyc + 1;
                    end
                end
            end
            if (e0 || e1) begin
                if (sel == mown) idle_cnt = 0;
                mown = sel;
                busy = 1;
                gcyc = cyc;
                q.push_back('{cyc + 1, sel, sel ? bus.m1_wr : bus.m0_wr,
                              sel ? bus.m1_addr : bus.m0_addr,
                              sel ? bus.m1_din  : bus.m0_din});
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge nfc_clk) begin
        item_t      it;
        logic [7:0] expd;
        if (!rstb_nfc) begin
            chk("reset_outputs", {bus.arb_nfc_reg_rd, bus.arb_nfc_reg_wr, bus.m0_ack, bus.m1_ack,
                                  bus.arb_owner, bus.arb_lock_to, |bus.arb_nfc_reg_addr,
                                  |bus.arb_nfc_reg_din, |bus.m0_dout, |bus.m1_dout}, 0);
            last_dout[0] = 0;
            last_dout[1] = 0;
        end else begin
            hist[cyc % 16] = bus.nfc_arb_reg_dout;
            if (q.size() > 0 && q[0].scyc == cyc) begin
                chk("strobe_wr", bus.arb_nfc_reg_wr, q[0].wr);
                chk("strobe_rd", bus.arb_nfc_reg_rd, !q[0].wr);
                chk("strobe_addr", bus.arb_nfc_reg_addr, q[0].addr);
                chk("strobe_din", bus.arb_nfc_reg_din, q[0].din);
                chk("owner", bus.arb_owner, q[0].m);
            end else if (bus.arb_nfc_reg_rd || bus.arb_nfc_reg_wr ||
                         bus.arb_nfc_reg_addr != 0 || bus.arb_nfc_reg_din != 0) begin
                chk("idle_bus", {bus.arb_nfc_reg_rd, bus.arb_nfc_reg_wr,
                                 bus.arb_nfc_reg_addr, bus.arb_nfc_reg_din}, 0);
            end
            if (q.size() > 0 && q[0].scyc + 2 == cyc) begin
                it   = q.pop_front();
                expd = it.wr ? last_dout[it.m] : hist[(it.scyc + 1) % 16];
                chk("ack_m0", bus.m0_ack, !it.m);
                chk("ack_m1", bus.m1_ack, it.m);
                chk("dout_owner", it.m ? bus.m1_dout : bus.m0_dout, expd);
                chk("dout_other", it.m ? bus.m0_dout : bus.m1_dout, last_dout[!it.m]);
                last_dout[it.m] = expd;
            end else if (bus.m0_ack || bus.m1_ack) begin
                chk("spurious_ack", {bus.m0_ack, bus.m1_ack}, 0);
            end
            if (bus.arb_lock_to || cyc == exp_lto)
                chk("lock_to", bus.arb_lock_to, cyc == exp_lto);
        end
    end

    initial begin
        forever begin
            @(posedge nfc_clk);
            #1;
            if (dout_rand) bus.nfc_arb_reg_dout = 8'($urandom);
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
    task automatic issue(input bit m, input bit wr, input bit lk,
                         input logic [8:0] addr, input logic [7:0] din);
        int n = 0;
        if (m) begin
            bus.m1_wr = wr; bus.m1_lock = lk; bus.m1_addr = addr; bus.m1_din = din; bus.m1_req = 1;
        end else begin
            bus.m0_wr = wr; bus.m0_lock = lk; bus.m0_addr = addr; bus.m0_din = din; bus.m0_req = 1;
        end
        do begin
            @(negedge nfc_clk);
            n++;
        end while (!(m ? bus.m1_ack : bus.m0_ack) && n < 2000);
        if (n >= 2000) chk("ack_wait", 0, 1);
        @(posedge nfc_clk);
        #1;
        if (m) bus.m1_req = 0;
        else   bus.m0_req = 0;
    endtask

    task automatic rnd_master(input bit m, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge nfc_clk);
                #1;
            end
            issue(m, 1'($urandom), ($urandom % 4) == 0, 9'($urandom), 8'($urandom));
        end
        if (m) bus.m1_lock = 0;
        else   bus.m0_lock = 0;
    endtask

    initial begin
        bus.m0_req = 0; bus.m0_wr = 0; bus.m0_lock = 0; bus.m0_addr = 0; bus.m0_din = 0;
        bus.m1_req = 0; bus.m1_wr = 0; bus.m1_lock = 0; bus.m1_addr = 0; bus.m1_din = 0;
        bus.nfc_arb_reg_dout = 0;
        rstb_nfc = 0;
        repeat (3) @(negedge nfc_clk);
        #2 rstb_nfc = 1;
        @(posedge nfc_clk);
        #1;

        // lone m0 write
        issue(0, 1, 0, 9'h0A5, 8'h44);
        repeat (3) begin @(posedge nfc_clk); #1; end

        // m1 read with a fixed nfc read value
        dout_rand = 0;
        bus.nfc_arb_reg_dout = 8'h5C;
        issue(1, 0, 0, 9'h010, 8'h00);
        dout_rand = 1;

        // simultaneous requests alternate
        repeat (4) begin
            fork
                issue(0, 1'($urandom), 0, 9'($urandom), 8'($urandom));
                issue(1, 1'($urandom), 0, 9'($urandom), 8'($urandom));
            join
        end

        // m1 holds the lock across three writes while m0 waits
        fork
            begin
                repeat (3) issue(1, 1, 1, 9'($urandom), 8'($urandom));
                bus.m1_lock = 0;
            end
            begin
                @(posedge nfc_clk);
                #1;
                issue(0, 1, 0, 9'h1F0, 8'hC3);
            end
        join

        // m0 locks then idles; m1 gets in after the timeout
        issue(0, 1, 1, 9'h033, 8'h99);
        issue(1, 0, 0, 9'h044, 8'h00);
        bus.m0_lock = 0;
        repeat (2) begin @(posedge nfc_clk); #1; end

        // reset during the strobe cycle of an m0 write
        bus.m0_wr = 1; bus.m0_lock = 0; bus.m0_addr = 9'h123; bus.m0_din = 8'hAB; bus.m0_req = 1;
        begin
            int n = 0;
            do begin
                @(negedge nfc_clk);
                n++;
            end while (!bus.arb_nfc_reg_wr && n < 50);
            if (n >= 50) chk("strobe_wait", 0, 1);
        end
        #2 rstb_nfc = 0;
        #1;
        chk("rst_async_bus", {bus.arb_nfc_reg_rd, bus.arb_nfc_reg_wr,
                              bus.arb_nfc_reg_addr, bus.arb_nfc_reg_din}, 0);
        bus.m0_req = 0;
        repeat (2) @(negedge nfc_clk);
        #2 rstb_nfc = 1;
        @(posedge nfc_clk);
        #1;
        issue(0, 1, 0, 9'h123, 8'hAB);

        // random traffic from both masters
        fork
            rnd_master(0, 30);
            rnd_master(1, 30);
        join

        repeat (20) @(posedge nfc_clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
